seq_mult_ctrl: RTL

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier.
// One partial-product step per clock; the W-bit add is built from chained
// 4-bit carry-lookahead slices. out_P is loaded only when a multiply completes.
module seq_mult_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   in_A,
    input  logic [W-1:0]   in_B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] out_P
);

    localparam int unsigned NumSlices = W / 4;
    localparam int unsigned CntW      = $clog2(W);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    m_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    q_q;
    logic            c_q;
    logic [CntW-1:0] cnt_q;

    logic [NumSlices:0] slice_c;
    logic [W-1:0]       sum;
    logic               c_step;
    logic [W-1:0]       acc_step;
    logic [W-1:0]       acc_shift;
    logic [W-1:0]       q_shift;

    assign slice_c[0] = 1'b0;

    // ACC + M from 4-bit CLA slices, slice carry-out feeding the next carry-in
    for (genvar s = 0; s < NumSlices; s++) begin : g_cla
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;

        assign a    = acc_q[s*4 +: 4];
        assign b    = m_q[s*4 +: 4];
        assign g    = a & b;
        assign p    = a ^ b;
        assign c[0] = slice_c[s];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign sum[s*4 +: 4] = p ^ c[3:0];
        assign slice_c[s+1]  = c[4];
    end

    // One iteration: conditional add, then shift {C,ACC,Q} right with 0 entering at the top
    always_comb begin
        // c_q is always zero between steps since every shift clears it
        c_step   = c_q;
        acc_step = acc_q;
        if (q_q[0]) begin
            c_step   = slice_c[NumSlices];
            acc_step = sum;
        end
        acc_shift = {c_step, acc_step[W-1:1]};
        q_shift   = {acc_step[0], q_q[W-1:1]};
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out_P   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= StCalc;
                        m_q     <= in_A;
                        q_q     <= in_B;
                        acc_q   <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StCalc: begin
                    acc_q <= acc_shift;
                    q_q   <= q_shift;
                    c_q   <= 1'b0;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(W - 1)) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        out_P   <= {acc_shift, q_shift};
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
